// File: rtl/fir_pkg.sv
// Shared constants and types for the 2D FIR multiplier datapath.
// PP_W is tied to the NOR partial-product cell output width.
package fir_pkg;

    localparam int PP_W       = 12;
    localparam int DEF_ACC_W  = 16;
    localparam int DEF_NUM_PP = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/pp_accumulator.sv
// Re-inverts NOR-cell partial products and sums NUM_PP of them per result,
// presenting the sum on a valid/ready port with a sticky carry-out flag.
module pp_accumulator
    import fir_pkg::*;
#(
    parameter int NUM_PP = DEF_NUM_PP,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PP_W-1:0]  prtprod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf
);

    localparam int CNT_W = $clog2(NUM_PP + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PP - 1);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic [PP_W-1:0]  pp_raw;
    logic [ACC_W-1:0] pp;
    logic [ACC_W:0]   sum_full;
    logic [ACC_W-1:0] sum;
    logic             carry;
    logic             accept;

    // The NOR cells emit the complement, so an all-ones word is a zero term.
    assign pp_raw   = ~prtprod;
    assign pp       = ACC_W'(pp_raw);
    assign sum_full = {1'b0, acc} + {1'b0, pp};
    assign sum      = sum_full[ACC_W-1:0];
    assign carry    = sum_full[ACC_W];

    assign in_ready = (state != DONE);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc   <= pp;
                        ovf   <= 1'b0;
                        cnt   <= CNT_W'(1);
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc <= sum;
                        ovf <= ovf | carry;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST_CNT) begin
                            out_data  <= sum;
                            out_ovf   <= ovf | carry;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    // New terms wait until the result has left, costing one bubble.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        cnt       <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/pp_accumulator.md
Name: pp_accumulator

Overview:
Downstream stage of the NOR partial-product cells in the 2D FIR multiplier datapath. Accepts one inverted 12-bit partial product per handshake. Re-inverts it and accumulates NUM_PP consecutive terms into one product/tap sum. Presents the result on a valid/ready output port with a sticky overflow flag.

Parameters:
NUM_PP, 8, partial products summed per result; legal range 2..16
PP_W, 12, partial-product width; fixed to match the NOR cell output
ACC_W, 16, accumulator and result width; must be >= PP_W

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
clear  input  1  synchronous abort of the current accumulation
in_valid  input  1  prtprod is valid this cycle
in_ready  output  1  block accepts prtprod this cycle
prtprod  input  PP_W  inverted partial product from the NOR cells
out_valid  output  1  result available
out_ready  input  1  consumer accepts the result
out_data  output  ACC_W  accumulated sum
out_ovf  output  1  carry out of ACC_W occurred during this result

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, acc=0, cnt=0, ovf=0.
  - out_valid=0, out_data=0, out_ovf=0.
  - rst has priority over every other input.
- Decode: pp = ~prtprod, zero-extended to ACC_W bits (unsigned).
- Accept: a term is accepted when in_valid && in_ready.
- in_ready: 1 in IDLE and ACCUM, 0 in DONE. It is combinational from state only and never depends on in_valid.
- IDLE:
  - On accept: acc<=pp, ovf<=0, cnt<=1, go to ACCUM.
- ACCUM:
  - On accept: {carry, sum} = acc + pp computed modulo 2^ACC_W.
  - acc<=sum, ovf<=ovf|carry, cnt<=cnt+1.
  - If cnt==NUM_PP-1: out_data<=sum, out_ovf<=ovf|carry, out_valid<=1, go to DONE.
  - If in_valid is low, hold all state. Gaps of any length are legal.
- DONE:
  - out_valid=1. out_data and out_ovf are held stable until the consumer accepts.
  - On out_ready: out_valid<=0, acc<=0, cnt<=0, go to IDLE.
  - Consequence: one bubble cycle between results. Accepting a new term in the same cycle as the output handshake is not supported.
- Latency: out_valid rises in the cycle after the NUM_PP-th accepted term.
- Throughput: at most one result per NUM_PP+1 cycles.
- clear=1 (when rst=0):
  - Effect: acc=0, cnt=0, ovf=0, state=IDLE, out_valid=0.
  - Any pending result is discarded.
  - A prtprod presented in the same cycle is dropped.
- Counter width: ceil(log2(NUM_PP+1)) bits; it never wraps within a result.
- The all-ones prtprod that the NOR cell emits while its rst is high decodes to pp=0. It is accumulated as a legal zero term.
- The state encoding has no illegal-state recovery requirement beyond reset.

Decomposition:
- Shared package fir_pkg holds:
  - PP_W=12 constant.
  - Default ACC_W and NUM_PP.
  - State enum {IDLE, ACCUM, DONE}.
- No sub-module needed. The adder, counter and FSM fit in a single module of about 150 lines.

Test Plan:
- Basic sum: NUM_PP=8, ACC_W=16; eight back-to-back prtprod=12'hFFE (pp=1) -> out_valid one cycle after the 8th accept, out_data=16'd8, out_ovf=0.
- Max terms: eight prtprod=12'h000 (pp=4095) with random in_valid gaps -> out_data=16'h7FF8, out_ovf=0, no term lost or duplicated.
- Overflow: ACC_W=12, NUM_PP=2; two prtprod=12'h000 -> out_data=12'hFFE, out_ovf=1. Next result of two pp=1 -> out_ovf=0.
- Backpressure: out_ready low for 5 cycles after a result -> out_data/out_ovf stable, in_ready=0, extra in_valid ignored. out_ready high -> out_valid=0 next cycle, in_ready=1.
- Reset mid-operation: rst for 1 cycle after 3 accepted terms -> all outputs 0, state IDLE. The next 8 terms of pp=2 -> out_data=16.
- Clear: clear with in_valid high after 5 terms, including the same cycle as a term -> that term dropped, out_valid stays 0. The next full set sums only post-clear terms.
